// File: rtl/pitfall_pixel_scheduler_pkg.sv
// Shared types and constants for the Pitfall pixel scheduler slice.
// Imported by the interface, the flash FSM and the scheduler top.
package pitfall_pkg;

  typedef logic [5:0] palette_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } flash_state_t;

  localparam palette_idx_t TRANSP_IDX_DEF = 6'h3F;
  localparam palette_idx_t BG_IDX_RST     = 6'h0F;
  localparam palette_idx_t FLASH_IDX_RST  = 6'h3E;
  localparam int           H_VIS_DEF      = 640;
  localparam int           V_VIS_DEF      = 480;

endpackage

// File: rtl/pitfall_pixel_scheduler_if.sv
// Pixel/config/flash signal bundle between the layer logic and the scheduler.
// PITFALL_SCHED_COLLISION_EN adds the collision statistics outputs.
interface pitfall_pixel_scheduler_if
  import pitfall_pkg::*;
#(
  parameter int NUM_LAYERS = 4
);

  logic                      frame_start;
  logic [9:0]                DrawX;
  logic [9:0]                DrawY;
  logic [NUM_LAYERS-1:0]     layer_valid;
  logic [6*NUM_LAYERS-1:0]   layer_idx;
  logic                      cfg_we;
  logic                      cfg_sel;
  palette_idx_t              cfg_data;
  logic                      flash_req;
  logic                      flash_busy;
  palette_idx_t              value;
  logic [2:0]                value_layer;
  logic                      value_valid;
`ifdef PITFALL_SCHED_COLLISION_EN
  logic [15:0]               collision_cnt;
  logic                      collision_flag;

  modport master (
    output frame_start, DrawX, DrawY, layer_valid, layer_idx,
    output cfg_we, cfg_sel, cfg_data, flash_req,
    input  flash_busy, value, value_layer, value_valid,
    input  collision_cnt, collision_flag
  );

  modport slave (
    input  frame_start, DrawX, DrawY, layer_valid, layer_idx,
    input  cfg_we, cfg_sel, cfg_data, flash_req,
    output flash_busy, value, value_layer, value_valid,
    output collision_cnt, collision_flag
  );
`else
  modport master (
    output frame_start, DrawX, DrawY, layer_valid, layer_idx,
    output cfg_we, cfg_sel, cfg_data, flash_req,
    input  flash_busy, value, value_layer, value_valid
  );

  modport slave (
    input  frame_start, DrawX, DrawY, layer_valid, layer_idx,
    input  cfg_we, cfg_sel, cfg_data, flash_req,
    output flash_busy, value, value_layer, value_valid
  );
`endif

endinterface

// File: rtl/pitfall_pixel_scheduler_flash_fsm.sv
// Frame-counted death/hit flash sequencer: FLASH_CYCLES pairs of ON/OFF phases,
// each phase FLASH_FRAMES frame_start pulses long.
module pitfall_flash_fsm
  import pitfall_pkg::*;
#(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_CYCLES = 3
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_start,
  input  logic flash_req,
  output logic flash_on,
  output logic flash_busy
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int PW = $clog2(FLASH_CYCLES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [PW-1:0] PAIR_LAST  = PW'(FLASH_CYCLES - 1);

  flash_state_t  state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      pair_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

  // A request in IDLE starts immediately; a coincident frame_start is not counted.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    pair_cnt_d  = pair_cnt_q;
    case (state_q)
      IDLE: begin
        if (flash_req) begin
          state_d     = ON;
          frame_cnt_d = '0;
          pair_cnt_d  = '0;
        end
      end
      ON: begin
        if (frame_start) begin
          if (frame_cnt_q == FRAME_LAST) begin
            state_d     = OFF;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      OFF: begin
        if (frame_start) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            if (pair_cnt_q == PAIR_LAST) begin
              state_d    = IDLE;
              pair_cnt_d = '0;
            end else begin
              state_d    = ON;
              pair_cnt_d = pair_cnt_q + PW'(1);
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        pair_cnt_d  = '0;
      end
    endcase
  end

  assign flash_on   = (state_q == ON);
  assign flash_busy = (state_q != IDLE);

endmodule

// File: rtl/pitfall_pixel_scheduler.sv
// Two-stage layer-priority pixel scheduler feeding the shared palette mapper,
// with flash override. Optional collision statistics: PITFALL_SCHED_COLLISION_EN.
module pitfall_pixel_scheduler
  import pitfall_pkg::*;
#(
  parameter int           NUM_LAYERS   = 4,
  parameter palette_idx_t TRANSP_IDX   = TRANSP_IDX_DEF,
  parameter int           FLASH_FRAMES = 8,
  parameter int           FLASH_CYCLES = 3,
  parameter int           H_VIS        = H_VIS_DEF,
  parameter int           V_VIS        = V_VIS_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  pitfall_pixel_scheduler_if.slave    bus
);

  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [2:0] BG_LAYER = 3'(NUM_LAYERS);

`ifdef PITFALL_SCHED_COLLISION_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction
`endif

  logic                    flash_on;
  logic                    flash_busy;
  palette_idx_t            bg_idx_q, flash_idx_q;
  logic [NUM_LAYERS-1:0]   lv_p1_q;
  logic [6*NUM_LAYERS-1:0] li_p1_q;
  logic                    vis_p1_q;
  logic [NUM_LAYERS-1:0]   opaque_p1;
  palette_idx_t            win_idx_p1;
  logic [2:0]              win_layer_p1;
  palette_idx_t            value_d, value_q;
  logic [2:0]              value_layer_d, value_layer_q;
  logic                    value_valid_d, value_valid_q;

  pitfall_flash_fsm #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_CYCLES (FLASH_CYCLES)
  ) u_flash_fsm (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (bus.frame_start),
    .flash_req   (bus.flash_req),
    .flash_on    (flash_on),
    .flash_busy  (flash_busy)
  );

  // Config registers: stage 2 reads the pre-write value during the write cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bg_idx_q    <= BG_IDX_RST;
      flash_idx_q <= FLASH_IDX_RST;
    end else if (bus.cfg_we) begin
      if (bus.cfg_sel) flash_idx_q <= bus.cfg_data;
      else             bg_idx_q    <= bus.cfg_data;
    end
  end

  // ---- stage 1: capture layer requests and visibility ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      lv_p1_q  <= '0;
      li_p1_q  <= '0;
      vis_p1_q <= 1'b0;
    end else begin
      lv_p1_q  <= bus.layer_valid;
      li_p1_q  <= bus.layer_idx;
      vis_p1_q <= (bus.DrawX < H_VIS_L) && (bus.DrawY < V_VIS_L);
    end
  end

  // Scanning from the bottom up leaves the lowest-numbered opaque layer in place.
  always_comb begin
    opaque_p1    = '0;
    win_idx_p1   = bg_idx_q;
    win_layer_p1 = BG_LAYER;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque_p1[i] = lv_p1_q[i] && (li_p1_q[6*i +: 6] != TRANSP_IDX);
      if (opaque_p1[i]) begin
        win_idx_p1   = li_p1_q[6*i +: 6];
        win_layer_p1 = 3'(i);
      end
    end
  end

  always_comb begin
    value_d       = '0;
    value_layer_d = BG_LAYER;
    value_valid_d = 1'b0;
    if (vis_p1_q) begin
      value_d       = flash_on ? flash_idx_q : win_idx_p1;
      value_layer_d = win_layer_p1;
      value_valid_d = 1'b1;
    end
  end

  // ---- stage 2: registered mapper outputs ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      value_q       <= '0;
      value_layer_q <= BG_LAYER;
      value_valid_q <= 1'b0;
    end else begin
      value_q       <= value_d;
      value_layer_q <= value_layer_d;
      value_valid_q <= value_valid_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_layer = value_layer_q;
  assign bus.value_valid = value_valid_q;
  assign bus.flash_busy  = flash_busy;

`ifdef PITFALL_SCHED_COLLISION_EN
  logic        coll_p1;
  logic [15:0] coll_cnt_d, coll_cnt_q;
  logic        coll_flag_d, coll_flag_q;

  assign coll_p1 = vis_p1_q && ($countones(opaque_p1) > 1);

  // frame_start has priority over a collision in the same cycle.
  always_comb begin
    coll_cnt_d  = coll_cnt_q;
    coll_flag_d = coll_flag_q;
    if (bus.frame_start) begin
      coll_cnt_d  = '0;
      coll_flag_d = 1'b0;
    end else if (coll_p1) begin
      coll_cnt_d  = sat_inc16(coll_cnt_q);
      coll_flag_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      coll_cnt_q  <= '0;
      coll_flag_q <= 1'b0;
    end else begin
      coll_cnt_q  <= coll_cnt_d;
      coll_flag_q <= coll_flag_d;
    end
  end

  assign bus.collision_cnt  = coll_cnt_q;
  assign bus.collision_flag = coll_flag_q;
`endif

endmodule

// File: doc/pitfall_pixel_scheduler.md
Name: pitfall_pixel_scheduler

Overview:
- Shares the single 64-entry palette colour mapper among several sprite/tile layers (Harry, hazards, vine, scenery).
- Each pixel cycle it picks the highest-priority opaque layer index, or the configured background index, and emits one 6-bit palette value to the mapper.
- A frame-based flash FSM sequences a death/hit effect by substituting a flash index on alternate frame groups.
- Sits between the per-layer sprite/frame logic and the colour mapper, ahead of the VGA output.

Parameters:
- NUM_LAYERS, 4, number of requesting layers; layer 0 has highest priority.
- TRANSP_IDX, 6'h3F, palette index that marks a layer pixel as transparent.
- FLASH_FRAMES, 8, frames per flash phase (ON or OFF).
- FLASH_CYCLES, 3, number of ON/OFF pairs per flash sequence.
- H_VIS, 640, visible width; V_VIS, 480, visible height.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- layer_valid  in  NUM_LAYERS  layer i drives a pixel this cycle
- layer_idx  in  6*NUM_LAYERS  packed palette indices; layer i occupies bits [6i+5:6i]
- cfg_we  in  1  write strobe for background/flash config
- cfg_sel  in  1  0 = background index, 1 = flash index
- cfg_data  in  6  config data
- flash_req  in  1  pulse that starts a flash sequence
- flash_busy  out  1  flash sequence in progress
- value  out  6  palette index to the colour mapper
- value_layer  out  3  winning layer number; NUM_LAYERS means background
- value_valid  out  1  value is for a visible pixel

Behaviour:
- Reset (Clk edge with Reset_n=0): value=0, value_layer=NUM_LAYERS, value_valid=0, flash_busy=0, bg_idx=6'h0F, flash_idx=6'h3E, FSM=IDLE, all counters=0, pipeline cleared. Reset in mid-sequence aborts the flash immediately.
- Pipeline, fixed latency 2:
  - Stage 1 registers layer_valid, layer_idx and vis=(DrawX<H_VIS)&&(DrawY<V_VIS).
  - Stage 2 selects and registers the outputs.
  - Inputs sampled at edge N appear on the outputs after edge N+2.
  - There is no stall and no backpressure.
- Selection:
  - A layer is opaque when layer_valid[i]=1 and layer_idx[i]!=TRANSP_IDX.
  - The lowest-numbered opaque layer wins.
  - If no layer is opaque, value=bg_idx and value_layer=NUM_LAYERS.
  - If vis=0, value=0, value_valid=0, value_layer=NUM_LAYERS.
- Flash override: while the FSM is in ON, visible pixels use value=flash_idx; value_layer still reports the true winner.
- Config:
  - A cfg_we write takes effect for pixels entering stage 2 on the next cycle.
  - A write in the same cycle as a stage-2 select uses the old value.
- Flash FSM, advanced only on frame_start:
  - IDLE: flash_req → ON; reload frame_cnt=0 and pair_cnt=0.
  - ON: frame_cnt counts frame_start pulses. After FLASH_FRAMES pulses → OFF, frame_cnt=0.
  - OFF: after FLASH_FRAMES pulses, pair_cnt+1. If pair_cnt+1==FLASH_CYCLES → IDLE, else → ON.
  - flash_busy=1 in ON and OFF.
  - flash_req while busy is ignored, with no restart.
  - flash_req and frame_start in the same cycle in IDLE: go to ON. That frame_start is not counted.
- Counter widths are $clog2(FLASH_FRAMES+1) and $clog2(FLASH_CYCLES+1); no wrap is reachable.

Optional Feature:
- Macro PITFALL_SCHED_COLLISION_EN.
- When defined:
  - Adds output collision_cnt (16 bits).
  - A pixel counts as a collision when a visible stage-2 pixel has two or more opaque layers.
  - The counter increments per collision pixel and saturates at 16'hFFFF.
  - It clears on frame_start; frame_start wins over a simultaneous increment.
  - Adds output collision_flag (1 bit): set on the first collision in a frame, cleared on frame_start.
- When undefined: neither port nor logic exists; the rest of the behaviour is unchanged.

Decomposition:
- Package pitfall_pkg holds:
  - typedef palette_idx_t (logic [5:0]);
  - the flash FSM state enum (IDLE, ON, OFF);
  - constants TRANSP_IDX_DEF, BG_IDX_RST, FLASH_IDX_RST, H_VIS_DEF, V_VIS_DEF.
- One sub-module is natural: pitfall_flash_fsm (frame_start, flash_req → flash_on, flash_busy), instantiated once.
- Priority selection stays inline.

Test Plan:
- Reset, then DrawX=10, DrawY=10, no layer valid → two cycles later value=6'h0F, value_layer=4, value_valid=1.
- Layers 1 and 3 valid with indices 6'h23 and 6'h11 → value=6'h23, value_layer=1. Layer 0 valid with 6'h3F (transparent) → still layer 1. Check latency is exactly 2.
- DrawX=700 with layer 0 valid at 6'h05 → value=0, value_valid=0.
- cfg_we, cfg_sel=0, cfg_data=6'h2F, then an empty pixel → value=6'h2F.
- flash_req, then 48 frame_start pulses with default parameters:
  - value=6'h3E on visible pixels during frames 1-8, 17-24 and 33-40;
  - normal output in the OFF frames;
  - flash_busy falls after the 48th pulse;
  - a second flash_req at frame 10 is ignored.
- With PITFALL_SCHED_COLLISION_EN: 5 visible pixels with layers 0 and 2 both opaque → collision_cnt=5 and collision_flag=1. After frame_start both read 0. Reset_n=0 during a flash → flash_busy=0 on the next edge.
